// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer.
//   state_t   : FSM state encoding (ST_IDLE / ST_SHIFT)
//   frame_len : bits per frame; WIDTH, or WIDTH+1 when SIPO_PARITY_CHECK_EN
//               appends an even-parity bit.
package sipo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int unsigned frame_len(input int unsigned width);
`ifdef SIPO_PARITY_CHECK_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for the SIPO deserializer.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low clear
//   load    : synchronous load of 1 (first bit of a frame accepted)
//   inc     : synchronous increment (further bit accepted)
//   last    : count has reached LAST, i.e. every bit of the frame is in
module sipo_bit_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned LAST  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(LAST));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out capture stage, LSB first.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds a trailing even-parity
// bit to each frame and drives parity_err; port list is identical).
// Ports:
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   d_in        : serial data bit, consumed when shift_en=1
//   shift_en    : bit qualifier
//   frame_start : d_in is the first bit of a frame (needs shift_en=1)
//   q_out       : last completed word, held until the next completion
//   q_valid     : one-cycle pulse when q_out updates
//   busy        : frame in progress
//   frame_abort : one-cycle pulse when a partial frame is discarded
//   parity_err  : one-cycle parity failure pulse, coincident with q_valid
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d_in,
    input  logic             shift_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid,
    output logic             busy,
    output logic             frame_abort,
    output logic             parity_err
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned CNT_W     = $clog2(WIDTH + 2);

    state_t                 state, state_next;
    logic [FRAME_LEN-1:0]   sreg, sreg_next;
    logic [FRAME_LEN-1:0]   first_word;
    logic                   load, inc, complete, abort;
    logic                   frame_done;
    logic                   par_fail;

    sipo_bit_counter #(
        .CNT_W (CNT_W),
        .LAST  (FRAME_LEN)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .inc     (inc),
        .last    (frame_done)
    );

    // New bits enter at the top and shift right, so after a full frame the
    // first bit sits at [0] and a parity bit (if any) at the top.
    assign first_word = {d_in, {(FRAME_LEN-1){1'b0}}};

`ifdef SIPO_PARITY_CHECK_EN
    assign par_fail = ^sreg;
`else
    assign par_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A full frame spends one cycle in SHIFT with the counter at its limit;
    // that cycle issues the completion and may already accept the next
    // frame_start, giving back-to-back frames with no bubble.
    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        load       = 1'b0;
        inc        = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        if (state == ST_IDLE) begin
            if (shift_en && frame_start) begin
                load       = 1'b1;
                sreg_next  = first_word;
                state_next = ST_SHIFT;
            end
        end else if (frame_done) begin
            complete = 1'b1;
            if (shift_en && frame_start) begin
                load      = 1'b1;
                sreg_next = first_word;
            end else begin
                state_next = ST_IDLE;
            end
        end else if (shift_en) begin
            if (frame_start) begin
                abort     = 1'b1;
                load      = 1'b1;
                sreg_next = first_word;
            end else begin
                inc       = 1'b1;
                sreg_next = {d_in, sreg[FRAME_LEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg        <= '0;
            q_out       <= '0;
            q_valid     <= 1'b0;
            frame_abort <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            sreg        <= sreg_next;
            q_valid     <= complete;
            frame_abort <= abort;
            parity_err  <= complete & par_fail;
            if (complete) begin
                q_out <= sreg[WIDTH-1:0];
            end
        end
    end

    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    localparam int unsigned WIDTH = 8;
`ifdef SIPO_PARITY_CHECK_EN
    localparam int unsigned FLEN = WIDTH + 1;
`else
    localparam int unsigned FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             d_in;
    logic             shift_en;
    logic             frame_start;
    logic [WIDTH-1:0] q_out;
    logic             q_valid;
    logic             busy;
    logic             frame_abort;
    logic             parity_err;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_in        (d_in),
        .shift_en    (shift_en),
        .frame_start (frame_start),
        .q_out       (q_out),
        .q_valid     (q_valid),
        .busy        (busy),
        .frame_abort (frame_abort),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: the bits of the current frame are kept in a queue;
    // once the queue holds a whole frame it is emitted on the following edge.
    bit               m_bits[$];
    bit               m_busy;
    logic [WIDTH-1:0] m_q;
    bit               m_qv, m_ab, m_pe;

    // Observations of DUT pulses, used by the literal checks.
    int               qv_cnt = 0;
    int               ab_cnt = 0;
    int               qv_cyc[$];
    logic [WIDTH-1:0] qv_word[$];
    logic             qv_busy[$];
    logic             qv_pe[$];

    function automatic void model_reset();
        m_bits.delete();
        m_busy = 0;
        m_q    = '0;
        m_qv   = 0;
        m_ab   = 0;
        m_pe   = 0;
    endfunction

    function automatic void model_step(input bit se, input bit fs, input bit d);
        longint unsigned w;
        bit p;
        m_qv = 0;
        m_ab = 0;
        m_pe = 0;
        if (m_busy && m_bits.size() == FLEN) begin
            w = 0;
            p = 0;
            for (int i = 0; i < int'(FLEN); i++) begin
                if (i < int'(WIDTH)) w = w + (longint'(m_bits[i]) << i);
                p = p ^ m_bits[i];
            end
            m_q  = WIDTH'(w);
            m_qv = 1;
`ifdef SIPO_PARITY_CHECK_EN
            m_pe = p;
`endif
            m_bits.delete();
            m_busy = 0;
            if (se && fs) begin
                m_bits.push_back(d);
                m_busy = 1;
            end
        end else if (se) begin
            if (fs) begin
                m_ab = m_busy;
                m_bits.delete();
                m_bits.push_back(d);
                m_busy = 1;
            end else if (m_busy) begin
                m_bits.push_back(d);
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        chk("q_out",       32'(q_out),       32'(m_q));
        chk("q_valid",     32'(q_valid),     32'(m_qv));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("frame_abort", 32'(frame_abort), 32'(m_ab));
        chk("parity_err",  32'(parity_err),  32'(m_pe));
        if (q_valid === 1'b1) begin
            qv_cnt++;
            qv_cyc.push_back(cyc);
            qv_word.push_back(q_out);
            qv_busy.push_back(busy);
            qv_pe.push_back(parity_err);
        end
        if (frame_abort === 1'b1) ab_cnt++;
    endtask

    task automatic step(input bit se, input bit fs, input bit d);
        @(negedge clk);
        shift_en    = se;
        frame_start = fs;
        d_in        = d;
        model_step(se, fs, d);
        @(posedge clk);
        #1;
        compare();
        cyc++;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input int unsigned gap, input bit bad_par);
        logic pbit;
        pbit = (^w) ^ bad_par;
        for (int i = 0; i < int'(FLEN); i++) begin
            step(1'b1, i == 0, (i < int'(WIDTH)) ? w[i] : pbit);
            if (i < int'(FLEN) - 1) begin
                for (int g = 0; g < int'(gap); g++) step(1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int s0, q0, a0;
        logic [WIDTH-1:0] tail;

        reset_n     = 1'b0;
        d_in        = 1'b0;
        shift_en    = 1'b0;
        frame_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q_out",   32'(q_out),       32'h0);
        chk("rst_q_valid", 32'(q_valid),     32'h0);
        chk("rst_busy",    32'(busy),        32'h0);
        chk("rst_abort",   32'(frame_abort), 32'h0);
        chk("rst_par",     32'(parity_err),  32'h0);
        reset_n = 1'b1;

        // Stray bits in IDLE are ignored.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        chk("stray_qv_cnt", 32'(qv_cnt), 32'd0);
        chk("stray_busy",   32'(busy),   32'h0);
        chk("stray_q_out",  32'(q_out),  32'h0);

        // 0xA5 with continuous shift_en.
        s0 = cyc;
        q0 = qv_cnt;
        send_frame(8'hA5, 0, 1'b0);
        idle(2);
        chk("a5_qv_cnt",  32'(qv_cnt - q0),  32'd1);
        chk("a5_word",    32'(qv_word[$]),   32'h0000_00A5);
        chk("a5_latency", 32'(qv_cyc[$]),    32'(s0 + int'(FLEN)));
        chk("a5_q_held",  32'(q_out),        32'h0000_00A5);

        // 0x3C with two idle cycles between bits.
        q0 = qv_cnt;
        send_frame(8'h3C, 2, 1'b0);
        idle(2);
        chk("3c_qv_cnt", 32'(qv_cnt - q0), 32'd1);
        chk("3c_word",   32'(qv_word[$]),  32'h0000_003C);

        // Partial frame of 4 bits, restarted by 0x81.
        q0 = qv_cnt;
        a0 = ab_cnt;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        send_frame(8'h81, 0, 1'b0);
        idle(2);
        chk("abort_cnt",    32'(ab_cnt - a0), 32'd1);
        chk("abort_qv_cnt", 32'(qv_cnt - q0), 32'd1);
        chk("abort_word",   32'(qv_word[$]),  32'h0000_0081);

        // Back-to-back 0x12 then 0x34.
        q0 = qv_cnt;
        send_frame(8'h12, 0, 1'b0);
        send_frame(8'h34, 0, 1'b0);
        idle(2);
        chk("b2b_qv_cnt",  32'(qv_cnt - q0),                  32'd2);
        chk("b2b_word0",   32'(qv_word[qv_word.size()-2]),    32'h0000_0012);
        chk("b2b_word1",   32'(qv_word[$]),                   32'h0000_0034);
        chk("b2b_spacing", 32'(qv_cyc[$] - qv_cyc[qv_cyc.size()-2]), 32'(FLEN));
        chk("b2b_busy_qv", 32'(qv_busy[qv_busy.size()-2]),   32'h1);

        // Asynchronous reset after the 5th bit of 0x5A.
        q0 = qv_cnt;
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, (8'h5A >> i) & 8'h01);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_q_out",   32'(q_out),       32'h0);
        chk("arst_q_valid", 32'(q_valid),     32'h0);
        chk("arst_busy",    32'(busy),        32'h0);
        chk("arst_abort",   32'(frame_abort), 32'h0);
        chk("arst_par",     32'(parity_err),  32'h0);
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tail = 8'h5A >> 5;
        for (int i = 5; i < int'(FLEN); i++) step(1'b1, 1'b0, (i < int'(WIDTH)) ? tail[i-5] : 1'b0);
        idle(2);
        chk("arst_qv_cnt",  32'(qv_cnt - q0), 32'd0);
        chk("arst_busy_after", 32'(busy),     32'h0);

`ifdef SIPO_PARITY_CHECK_EN
        send_frame(8'h07, 0, 1'b0);
        idle(2);
        chk("par_ok_word", 32'(qv_word[$]), 32'h0000_0007);
        chk("par_ok_err",  32'(qv_pe[$]),   32'h0);
        send_frame(8'h07, 0, 1'b1);
        idle(2);
        chk("par_bad_word", 32'(qv_word[$]), 32'h0000_0007);
        chk("par_bad_err",  32'(qv_pe[$]),   32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
